// File: rtl/snn_pkg.sv
// snn_pkg: shared defaults, FSM encoding and saturation bounds for the SNN datapath
package snn_pkg;
    localparam int DEF_V_SIZE = 4;
    localparam int DEF_W_SIZE = 4;
    localparam int DEF_N_IN = 8;
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    function automatic int sat_max(input int v_size);
        return (1 << (v_size - 1)) - 1;
    endfunction
    function automatic int sat_min(input int v_size);
        return -(1 << (v_size - 1));
    endfunction
endpackage

// File: rtl/synapse_accum_if.sv
// synapse_accum_if: timestep request, spike/weight vectors and accumulated current result
interface synapse_accum_if import snn_pkg::*; #(
    parameter int N_IN = DEF_N_IN,
    parameter int V_SIZE = DEF_V_SIZE,
    parameter int W_SIZE = DEF_W_SIZE
);
    logic start;
    logic [N_IN-1:0] spikes_in;
    logic [N_IN*W_SIZE-1:0] weights;
    logic busy;
    logic out_valid;
    logic signed [V_SIZE-1:0] sum_out;
    modport master (output start, spikes_in, weights, input busy, out_valid, sum_out);
    modport slave (input start, spikes_in, weights, output busy, out_valid, sum_out);
endinterface

// File: rtl/sat_add_step.sv
// sat_add_step: combinational signed saturating add of a weight onto an accumulator
module sat_add_step import snn_pkg::*; #(
    parameter int V_SIZE = DEF_V_SIZE,
    parameter int W_SIZE = DEF_W_SIZE
) (
    input logic signed [V_SIZE-1:0] acc,
    input logic signed [W_SIZE-1:0] w,
    output logic signed [V_SIZE-1:0] sum
);
    localparam logic signed [V_SIZE:0] HI = (V_SIZE + 1)'(sat_max(V_SIZE));
    localparam logic signed [V_SIZE:0] LO = (V_SIZE + 1)'(sat_min(V_SIZE));
    logic signed [V_SIZE:0] raw;
    // one guard bit is enough since W_SIZE <= V_SIZE keeps the true sum in range
    always_comb begin
        raw = {acc[V_SIZE-1], acc} + {{(V_SIZE + 1 - W_SIZE){w[W_SIZE-1]}}, w};
        sum = raw > HI ? HI[V_SIZE-1:0] : raw < LO ? LO[V_SIZE-1:0] : raw[V_SIZE-1:0];
    end
endmodule

// File: rtl/synapse_accum.sv
// synapse_accum: serial saturating spike-weighted sum, one synapse per clock
// Optional SYN_SKIP_ZERO_EN: visit only set spike bits via a priority encoder
module synapse_accum import snn_pkg::*; #(
    parameter int N_IN = DEF_N_IN,
    parameter int V_SIZE = DEF_V_SIZE,
    parameter int W_SIZE = DEF_W_SIZE
) (
    input logic clk,
    input logic rst,
    synapse_accum_if.slave bus
);
    localparam int IW = N_IN > 1 ? $clog2(N_IN) : 1;
    state_t state, nxt;
    logic [N_IN-1:0] spk;
    logic [IW-1:0] idx;
    logic signed [V_SIZE-1:0] acc, step, acc_nxt, sum_r;
    logic signed [W_SIZE-1:0] w_cur;
    logic busy_r, valid_r, last, direct;

    assign w_cur = bus.weights[idx*W_SIZE +: W_SIZE];
    assign acc_nxt = spk[idx] ? step : acc;

    sat_add_step #(.V_SIZE(V_SIZE), .W_SIZE(W_SIZE)) u_step (
        .acc(acc),
        .w(w_cur),
        .sum(step)
    );

`ifdef SYN_SKIP_ZERO_EN
    logic [N_IN-1:0] rem;
    assign rem = spk & ~(N_IN'(1) << idx);
    assign last = rem == '0;
    assign direct = bus.spikes_in == '0;
    // lowest remaining set bit selects the synapse to visit
    always_comb begin
        idx = '0;
        for (int i = N_IN - 1; i >= 0; i--) if (spk[i]) idx = IW'(i);
    end
    // latch spikes on accept, retire each visited bit
    always_ff @(posedge clk) begin
        if (rst) spk <= '0;
        else if (state == IDLE && bus.start) spk <= bus.spikes_in;
        else if (state == ACCUM) spk <= rem;
    end
`else
    assign last = idx == IW'(N_IN - 1);
    assign direct = 1'b0;
    // latch spikes on accept, step the synapse index while accumulating
    always_ff @(posedge clk) begin
        if (rst) begin
            spk <= '0;
            idx <= '0;
        end else if (state == IDLE && bus.start) begin
            spk <= bus.spikes_in;
            idx <= '0;
        end else if (state == ACCUM) begin
            idx <= idx + 1'b1;
        end
    end
`endif

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= nxt;
    end

    // next state: an all-zero vector in skip mode goes straight to DONE
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: if (bus.start) nxt = direct ? DONE : ACCUM;
            ACCUM: if (last) nxt = DONE;
            default: nxt = IDLE;
        endcase
    end

    // accumulator, registered status and result capture on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            sum_r <= '0;
            busy_r <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            busy_r <= nxt != IDLE;
            valid_r <= nxt == DONE;
            if (nxt == DONE) sum_r <= state == ACCUM ? acc_nxt : '0;
            if (state == IDLE && bus.start) acc <= '0;
            else if (state == ACCUM) acc <= acc_nxt;
        end
    end

    assign bus.busy = busy_r;
    assign bus.out_valid = valid_r;
    assign bus.sum_out = sum_r;
endmodule

// File: tb/tb_synapse_accum.sv
// tb_synapse_accum: directed vector table plus reset/overlap sequences for synapse_accum
module tb_synapse_accum;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;

    synapse_accum_if #(.N_IN(4), .V_SIZE(4), .W_SIZE(4)) bus ();

    synapse_accum #(.N_IN(4), .V_SIZE(4), .W_SIZE(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        logic [3:0] spk;
        logic [15:0] w;
        int sum;
    } vec_t;

    vec_t v[8];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [3:0] s);
`ifdef SYN_SKIP_ZERO_EN
        return $countones(s) + 1;
`else
        return 5;
`endif
    endfunction

    task automatic issue(input logic [3:0] s, input logic [15:0] w);
        @(negedge clk);
        bus.start = 1'b1;
        bus.spikes_in = s;
        bus.weights = w;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic run_vec(input vec_t t);
        int cyc;
        int bad_busy;
        int lat;
        lat = exp_lat(t.spk);
        issue(t.spk, t.w);
        cyc = 0;
        bad_busy = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (bus.busy !== 1'b1) bad_busy++;
        end while (bus.out_valid !== 1'b1 && cyc < 20);
        chk({t.name, " latency"}, cyc, lat);
        chk({t.name, " sum"}, int'(bus.sum_out), t.sum);
        chk({t.name, " busy"}, bad_busy, 0);
        @(negedge clk);
        chk({t.name, " pulse"}, int'(bus.out_valid), 0);
        chk({t.name, " idle"}, int'(bus.busy), 0);
        chk({t.name, " hold"}, int'(bus.sum_out), t.sum);
    endtask

    initial begin
        int vcnt;
        int first;
        int second;
        int sum2;
        v[0] = '{"basic", 4'b0101, 16'h51E3, 4};
        v[1] = '{"pos_sat", 4'b1111, 16'h7777, 7};
        v[2] = '{"neg_sat", 4'b1111, 16'h8888, -8};
        v[3] = '{"order", 4'b0111, 16'h0877, -1};
        v[4] = '{"single", 4'b1000, 16'hD000, -3};
        v[5] = '{"zero", 4'b0000, 16'h7777, 0};
        v[6] = '{"mixed", 4'b1111, 16'hC321, 2};
        v[7] = '{"recover", 4'b1111, 16'h7788, 6};
        bus.start = 1'b0;
        bus.spikes_in = '0;
        bus.weights = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset busy", int'(bus.busy), 0);
        chk("reset valid", int'(bus.out_valid), 0);
        chk("reset sum", int'(bus.sum_out), 0);
        for (int i = 0; i < 8; i++) run_vec(v[i]);

        // reset two cycles into a run abandons it
        run_vec(v[1]);
        issue(4'b1111, 16'h7777);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst busy", int'(bus.busy), 0);
        chk("rst valid", int'(bus.out_valid), 0);
        chk("rst sum", int'(bus.sum_out), 0);
        vcnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) vcnt++;
        end
        chk("rst no valid", vcnt, 0);

        // start while busy and in DONE ignored; next accept at T+6
        issue(4'b1111, 16'h1111);
        vcnt = 0;
        first = 0;
        second = 0;
        sum2 = 99;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                vcnt++;
                if (first == 0) first = k;
                else begin
                    second = k;
                    sum2 = int'(bus.sum_out);
                end
            end
            bus.start = (k == 2 || k == 5 || k == 6);
        end
        bus.start = 1'b0;
        chk("overlap count", vcnt, 2);
        chk("overlap first", first, 5);
        chk("overlap second", second, 11);
        chk("overlap sum", sum2, 4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
